// File: rtl/rr_priority_arbiter.sv
// -----------------------------------------------------------------------------
// rr_priority_arbiter
//
// Shares one resource among N requesters. A winner is chosen by priority
// encoding, either fixed (highest index wins) or round-robin (search downward
// from just below the last winner, wrapping). The grant is registered and held
// while the holder keeps requesting. If MAX_HOLD is non-zero and others are
// waiting, the holder is preempted after MAX_HOLD consecutive cycles.
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   mode        0 = fixed priority, 1 = round-robin (used only when arbitrating)
//   req[N]      request vector, bit i = requester i wants the resource
//   grant[N]    registered one-hot grant, all-zero when idle
//   grant_idx   binary index of the grant holder, 0 when idle
//   grant_valid high while any grant is active
//   timeout     one-cycle pulse on the edge where MAX_HOLD preempts a holder
// -----------------------------------------------------------------------------
module rr_priority_arbiter #(
    parameter int N        = 8,
    parameter int IDX_W    = 3,
    parameter int MAX_HOLD = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mode,
    input  logic [N-1:0]     req,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_valid,
    output logic             timeout
);

    // hold_cnt only has to reach MAX_HOLD-1; MAX_HOLD of 0 or 1 needs one bit.
    localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST =
        (MAX_HOLD > 1) ? HOLD_W'(MAX_HOLD - 1) : '0;
    localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t            state;
    logic [HOLD_W-1:0] hold_cnt;
    logic [IDX_W-1:0]  last_idx;

    logic              holder_req;
    logic              hold_at_last;
    logic [N-1:0]      others;
    logic [IDX_W-1:0]  norm_idx;
    logic [IDX_W-1:0]  pre_idx;

    // Highest set index of c.
    function automatic logic [IDX_W-1:0] pick_fixed(input logic [N-1:0] c);
        logic [IDX_W-1:0] win;
        win = '0;
        for (int i = 0; i < N; i++) begin
            if (c[i]) win = IDX_W'(i);
        end
        return win;
    endfunction

    // First set bit of c searching downward from (last-1) mod N, wrapping.
    // Candidates are visited farthest-first so the nearest one overwrites.
    function automatic logic [IDX_W-1:0] pick_rr(input logic [N-1:0]     c,
                                                 input logic [IDX_W-1:0] last);
        logic [IDX_W-1:0] win;
        int               start;
        int               pos;
        win   = '0;
        start = (int'(last) + N - 1) % N;
        for (int k = N - 1; k >= 0; k--) begin
            pos = (start - k + N) % N;
            if (c[pos]) win = IDX_W'(pos);
        end
        return win;
    endfunction

    // NOTE: every signal assigned in always_comb gets a value on every path,
    // otherwise synthesis infers a latch.
    always_comb begin
        holder_req   = |(req & grant);
        others       = req & ~grant;
        // When the holder has dropped (or in IDLE) req equals others, so the
        // normal winner can be taken straight from req.
        norm_idx     = mode ? pick_rr(req, last_idx) : pick_fixed(req);
        // Preemption always rotates; last_idx equals the holder here, so the
        // search naturally starts just below it.
        pre_idx      = pick_rr(others, last_idx);
        hold_at_last = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST);
    end

    // NOTE: registered state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            grant       <= '0;
            grant_idx   <= '0;
            grant_valid <= 1'b0;
            timeout     <= 1'b0;
            hold_cnt    <= '0;
            last_idx    <= '0;
        end else begin
            timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (|req) begin
                        state       <= GRANT;
                        grant       <= ONE << norm_idx;
                        grant_idx   <= norm_idx;
                        grant_valid <= 1'b1;
                        last_idx    <= norm_idx;
                        hold_cnt    <= '0;
                    end
                end

                GRANT: begin
                    if (!holder_req) begin
                        if (|others) begin
                            // Direct handoff, no idle bubble.
                            grant     <= ONE << norm_idx;
                            grant_idx <= norm_idx;
                            last_idx  <= norm_idx;
                            hold_cnt  <= '0;
                        end else begin
                            state       <= IDLE;
                            grant       <= '0;
                            grant_idx   <= '0;
                            grant_valid <= 1'b0;
                            hold_cnt    <= '0;
                        end
                    end else if (!hold_at_last) begin
                        // Saturate so the unlimited case never wraps.
                        if (hold_cnt != '1) hold_cnt <= hold_cnt + 1'b1;
                    end else if (|others) begin
                        grant     <= ONE << pre_idx;
                        grant_idx <= pre_idx;
                        last_idx  <= pre_idx;
                        hold_cnt  <= '0;
                        timeout   <= 1'b1;
                    end else begin
                        // Nobody waiting: restart the hold window silently.
                        hold_cnt <= '0;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rr_priority_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rr_priority_arbiter
//
// Directed bench for rr_priority_arbiter (N=8, IDX_W=3, MAX_HOLD=16).
// Inputs change 1 ns after a rising edge; outputs are sampled at that same
// point, so each step observes the result of the edge just taken.
// -----------------------------------------------------------------------------
module tb_rr_priority_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       mode;
    logic [7:0] req;
    logic [7:0] grant;
    logic [2:0] grant_idx;
    logic       grant_valid;
    logic       timeout;

    int n_checks = 0;
    int n_fail   = 0;

    rr_priority_arbiter #(
        .N       (8),
        .IDX_W   (3),
        .MAX_HOLD(16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .mode       (mode),
        .req        (req),
        .grant      (grant),
        .grant_idx  (grant_idx),
        .grant_valid(grant_valid),
        .timeout    (timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outs(input string tag, input logic [7:0] exp_grant,
                              input logic [2:0] exp_idx, input logic exp_to);
        check({tag, ".grant"}, 32'(grant), 32'(exp_grant));
        check({tag, ".idx"},   32'(grant_idx), 32'(exp_idx));
        check({tag, ".valid"}, 32'(grant_valid), 32'(exp_grant != 8'h00));
        check({tag, ".timeout"}, 32'(timeout), 32'(exp_to));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    // Hard stop in case something above ever stalls.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int h;
        int steps;

        rst  = 1'b1;
        mode = 1'b0;
        req  = 8'h00;
        step();
        rst = 1'b0;
        check_outs("reset", 8'h00, 3'd0, 1'b0);

        // Idle for 5 cycles.
        for (int i = 0; i < 5; i++) begin
            step();
            check_outs("idle", 8'h00, 3'd0, 1'b0);
        end

        // Fixed priority: highest index wins, then direct handoff.
        mode = 1'b0;
        req  = 8'b0010_0110;
        step();
        check_outs("fixed_first", 8'b0010_0000, 3'd5, 1'b0);
        req = 8'b0000_0110;
        step();
        check_outs("fixed_handoff", 8'b0000_0100, 3'd2, 1'b0);
        req = 8'h00;
        step();
        check_outs("release_idle", 8'h00, 3'd0, 1'b0);

        // Round-robin with all requesting: 7,6,...,0,7, 16 cycles each.
        do_reset();
        mode = 1'b1;
        req  = 8'hFF;
        step();
        for (int k = 0; k <= 8; k++) begin
            h = (7 - k + 8) % 8;
            check_outs("rot_grant", 8'(1 << h), 3'(h), k != 0);
            if (k == 8) break;
            for (int c = 1; c < 16; c++) begin
                step();
                check_outs("rot_hold", 8'(1 << h), 3'(h), 1'b0);
            end
            step();
        end

        // Lone requester 3 for 40 cycles: held throughout, never times out.
        req = 8'b0000_1000;
        step();
        check_outs("solo_grant", 8'b0000_1000, 3'd3, 1'b0);
        for (int i = 0; i < 40; i++) begin
            step();
            check_outs("solo_hold", 8'b0000_1000, 3'd3, 1'b0);
        end

        // Mode change plus a new requester mid-grant: no immediate preemption.
        // hold_cnt is 8 here, so the timeout lands on the 8th edge, and the
        // masked rotating search from index 2 wraps to 7.
        mode  = 1'b0;
        req   = 8'b1000_1000;
        steps = 0;
        do begin
            step();
            steps++;
            if (!timeout) check_outs("mode_no_preempt", 8'b0000_1000, 3'd3, 1'b0);
        end while (!timeout && steps < 30);
        check("preempt_latency", 32'(steps), 32'd8);
        check_outs("preempt_grant", 8'b1000_0000, 3'd7, 1'b1);
        step();
        check("timeout_one_cycle", 32'(timeout), 32'd0);

        // Round-robin wrap: holder 0 drops, search from 7 picks 7.
        do_reset();
        mode = 1'b1;
        req  = 8'b0000_0001;
        step();
        check_outs("wrap_hold0", 8'b0000_0001, 3'd0, 1'b0);
        req = 8'b1000_0010;
        step();
        check_outs("wrap_to7", 8'b1000_0000, 3'd7, 1'b0);

        // Round-robin vs fixed on the same pattern after holder 5 drops.
        do_reset();
        mode = 1'b1;
        req  = 8'b0010_0000;
        step();
        check_outs("rr_hold5", 8'b0010_0000, 3'd5, 1'b0);
        req = 8'b1001_0000;
        step();
        check_outs("rr_below5", 8'b0001_0000, 3'd4, 1'b0);

        do_reset();
        mode = 1'b0;
        req  = 8'b0010_0000;
        step();
        check_outs("fx_hold5", 8'b0010_0000, 3'd5, 1'b0);
        req = 8'b1001_0000;
        step();
        check_outs("fx_highest", 8'b1000_0000, 3'd7, 1'b0);

        // Reset mid-grant on index 4, then last_idx restarts from 0.
        req = 8'b0001_0000;
        step();
        check_outs("pre_rst_hold4", 8'b0001_0000, 3'd4, 1'b0);
        rst = 1'b1;
        step();
        check_outs("mid_reset", 8'h00, 3'd0, 1'b0);
        rst  = 1'b0;
        mode = 1'b1;
        req  = 8'b0001_0001;
        step();
        check_outs("post_reset_rr", 8'b0001_0000, 3'd4, 1'b0);

        req = 8'h00;
        step();
        check_outs("final_idle", 8'h00, 3'd0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rr_priority_arbiter.md
Name: rr_priority_arbiter

Overview:
- Sequential arbiter sharing one resource among N requesters, built around priority-encode selection.
- Two modes: fixed priority (highest index wins) and round-robin (rotating priority starting below the last winner).
- Grants are registered and held while the winner keeps its request asserted, bounded by a hold timeout.
- Sits in front of any shared datapath (bus, encoder output port, memory) that needs one owner at a time.

Parameters:
- N, 8, number of requesters (N >= 2).
- IDX_W, 3, width of the grant index; must satisfy 2**IDX_W >= N.
- MAX_HOLD, 16, maximum consecutive cycles one requester keeps the grant when others wait; 0 = unlimited.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous active-high reset.
- mode  input  1  0 = fixed priority, 1 = round-robin; sampled only at arbitration points.
- req  input  N  request vector; bit i high = requester i wants the resource.
- grant  output  N  one-hot grant, registered; all-zero when idle.
- grant_idx  output  IDX_W  binary index of the current grant holder; 0 when idle.
- grant_valid  output  1  high while any grant is active.
- timeout  output  1  one-cycle pulse on the edge where a holder is preempted by MAX_HOLD.

Behaviour:
- Reset (rst high at an edge): grant=0, grant_idx=0, grant_valid=0, timeout=0, state=IDLE, hold_cnt=0, last_idx=0. Reset overrides everything, including mid-grant, and takes effect on that edge.
- States: IDLE, GRANT.
- Winner selection (combinational, from a candidate vector C):
  - mode=0: highest set index in C.
  - mode=1: first set bit searching downward from (last_idx-1) mod N, wrapping. After reset last_idx=0, so the search starts at N-1 and gives the same result as fixed mode.
- IDLE:
  - If req != 0, next edge: state=GRANT, grant=onehot(winner of req), grant_idx=winner, grant_valid=1, last_idx=winner, hold_cnt=0.
  - Latency from req sampled high to grant_valid high is 1 cycle.
  - If req == 0, outputs stay 0.
- GRANT, holder h=grant_idx:
  - req[h]=0 and other requests pending: switch directly to the winner of req at the next edge, with no idle bubble. hold_cnt=0; last_idx is updated.
  - req[h]=0 and no other requests: next edge goes to IDLE and all outputs clear.
  - req[h]=1 and MAX_HOLD=0, or hold_cnt < MAX_HOLD-1: keep the grant and increment hold_cnt.
  - req[h]=1, hold_cnt == MAX_HOLD-1, and other requests pending: preempt.
    - The winner is taken from req with bit h masked, using the rotating search in both modes.
    - timeout=1 for exactly that cycle; hold_cnt=0.
  - req[h]=1, hold_cnt == MAX_HOLD-1, and no other requests: keep the grant, hold_cnt=0, no timeout.
- Invariants:
  - grant is always one-hot or zero.
  - grant_valid equals |grant.
  - grant_idx equals the encoded grant.
- A mode change mid-grant never preempts; it applies at the next arbitration.
- Requests from a non-holder never affect the current holder except through the timeout.
- hold_cnt is wide enough to hold MAX_HOLD-1 and never wraps.

Test Plan:
- Reset, then req=8'b00000000 for 5 cycles -> grant=0, grant_idx=0, grant_valid=0 throughout.
- mode=0, req=8'b00100110 -> one cycle later grant=8'b00100000, grant_idx=5.
  - Drop bit 5 -> next edge grant=8'b00000100, grant_idx=2, with no idle cycle.
- mode=1, req=8'b11111111 held, MAX_HOLD=16:
  - Grants rotate 7,6,5,...,0,7.
  - Each holder keeps the grant for exactly 16 cycles.
  - timeout pulses once per handoff.
- MAX_HOLD=16, only req[3] high for 40 cycles -> grant_idx=3 continuously, timeout never asserts.
- mode=1, grant on index 0, req[0] drops while req=8'b10000010 -> the wrapping search from index 7 gives grant_idx=7.
- Assert rst mid-grant (grant_idx=4) -> next edge all outputs 0.
  - With req=8'b00010001 and mode=1 after release, the next grant is index 4 because last_idx was reset to 0.
